// File: rtl/systolic_mac_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic MAC array.
// A job loads one weight tile, streams num_vec activation vectors through the
// array, then drains the skewed pipeline. Every output is a flop whose next
// value is derived from the next state, so outputs line up with their state.
module systolic_mac_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAX_VEC = 256,
  parameter int VEC_W   = $clog2(MAX_VEC + 1),
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vec,
  output logic             busy,
  output logic             done,
  output logic             prefetch,
  output logic             conv,
  output logic             w_rd_en,
  output logic [AW-1:0]    w_rd_addr,
  output logic             a_rd_en,
  output logic [VEC_W-1:0] a_rd_addr,
  output logic             p_valid,
  output logic [VEC_W-1:0] p_idx
);

  // The phase counter must reach num_vec+ROWS+COLS-1 for the largest job.
  localparam int CNT_W = $clog2(MAX_VEC + ROWS + COLS + 1);

  localparam logic [CNT_W-1:0] ROWS_C  = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] COLS_C  = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [VEC_W-1:0] MAXV_C  = VEC_W'(MAX_VEC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_CONV,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   num_vec_q, num_vec_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               prefetch_q, prefetch_d;
  logic               conv_q, conv_d;
  logic               w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]      w_rd_addr_q, w_rd_addr_d;
  logic               a_rd_en_q, a_rd_en_d;
  logic [VEC_W-1:0]   a_rd_addr_q, a_rd_addr_d;
  logic               p_valid_q, p_valid_d;
  logic [VEC_W-1:0]   p_idx_q, p_idx_d;

  logic [CNT_W-1:0]   conv_last_k;
  logic [CNT_W-1:0]   nv_ext_d;

  // Last CONV cycle index for the latched job: num_vec+ROWS+COLS-1.
  assign conv_last_k = CNT_W'(num_vec_q) + ROWS_C + COLS_C - ONE_C;

  // Next-state and phase counter; start is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_vec_d = (num_vec > MAXV_C) ? MAXV_C : num_vec;
          cnt_d     = '0;
          state_d   = ST_PREFETCH;
        end
      end
      ST_PREFETCH: begin
        if (cnt_q == ROWS_C - ONE_C) begin
          cnt_d   = '0;
          state_d = (num_vec_q == '0) ? ST_DONE : ST_CONV;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_CONV: begin
        if (cnt_q == conv_last_k) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state/count so the registered outputs
  // are valid in the same cycle the state they describe is entered.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    prefetch_d  = 1'b0;
    conv_d      = 1'b0;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = '0;
    a_rd_en_d   = 1'b0;
    a_rd_addr_d = '0;
    p_valid_d   = 1'b0;
    p_idx_d     = '0;
    nv_ext_d    = CNT_W'(num_vec_d);
    case (state_d)
      ST_PREFETCH: begin
        busy_d      = 1'b1;
        prefetch_d  = 1'b1;
        w_rd_en_d   = 1'b1;
        w_rd_addr_d = AW'(ROWS_C - ONE_C - cnt_d);
      end
      ST_CONV: begin
        busy_d = 1'b1;
        conv_d = 1'b1;
        if (cnt_d < nv_ext_d) begin
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = VEC_W'(cnt_d);
        end
        if ((cnt_d >= ROWS_C + ONE_C) && (cnt_d <= ROWS_C + nv_ext_d)) begin
          p_valid_d = 1'b1;
          p_idx_d   = VEC_W'(cnt_d - ROWS_C - ONE_C);
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counter, latched job length and all output flops; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      num_vec_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prefetch_q  <= 1'b0;
      conv_q      <= 1'b0;
      w_rd_en_q   <= 1'b0;
      w_rd_addr_q <= '0;
      a_rd_en_q   <= 1'b0;
      a_rd_addr_q <= '0;
      p_valid_q   <= 1'b0;
      p_idx_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_vec_q   <= num_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prefetch_q  <= prefetch_d;
      conv_q      <= conv_d;
      w_rd_en_q   <= w_rd_en_d;
      w_rd_addr_q <= w_rd_addr_d;
      a_rd_en_q   <= a_rd_en_d;
      a_rd_addr_q <= a_rd_addr_d;
      p_valid_q   <= p_valid_d;
      p_idx_q     <= p_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign prefetch  = prefetch_q;
  assign conv      = conv_q;
  assign w_rd_en   = w_rd_en_q;
  assign w_rd_addr = w_rd_addr_q;
  assign a_rd_en   = a_rd_en_q;
  assign a_rd_addr = a_rd_addr_q;
  assign p_valid   = p_valid_q;
  assign p_idx     = p_idx_q;

endmodule

// File: doc/systolic_mac_ctrl.md
Name: systolic_mac_ctrl

Overview:
- Sequencer for a ROWS x COLS weight-stationary systolic array built from the team's MAC cells.
- Each cell has prefetch/conv controls. prefetch shifts weights down the w chain. conv moves a right and accumulates p downward, with result = p_i + w*a registered.
- Per job: loads one weight tile (ROWS shift cycles), streams num_vec activation vectors, then flushes the skewed pipeline.
- Emits array controls, weight/activation read strobes, and a result-valid strobe for the bottom of column 0.

Parameters:
ROWS, 4, array rows (weight shift depth, accumulation depth)
COLS, 4, array columns (activation skew across columns)
MAX_VEC, 256, maximum activation vectors per job
VEC_W, $clog2(MAX_VEC+1), width of num_vec / indices

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  job request; sampled only in IDLE
num_vec  in  VEC_W  vectors in job; latched when start accepted; values >MAX_VEC saturate to MAX_VEC
busy  out  1  high in PREFETCH and CONV
done  out  1  one-cycle pulse in DONE
prefetch  out  1  to all MAC prefetch inputs
conv  out  1  to all MAC conv inputs
w_rd_en  out  1  weight row read strobe (same cycle as prefetch)
w_rd_addr  out  $clog2(ROWS)  weight row index; combinational-read source
a_rd_en  out  1  activation vector read strobe
a_rd_addr  out  VEC_W  activation vector index
p_valid  out  1  column-0 bottom p_o holds a finished result
p_idx  out  VEC_W  vector index of that result

Behaviour:
- All outputs are registered.
- Reset (rst=0, any time, including mid-job): state IDLE; counters 0; every output 0. No partial job resumes after release.
- States:
  - IDLE: start=1 latches num_vec and moves to PREFETCH.
  - PREFETCH: lasts exactly ROWS cycles, then CONV.
  - CONV: lasts L = num_vec+ROWS+COLS cycles, then DONE.
  - DONE: lasts 1 cycle, then IDLE.
- num_vec=0: PREFETCH runs, CONV is skipped (PREFETCH -> DONE). a_rd_en and p_valid never assert.
- PREFETCH cycle j (0..ROWS-1): prefetch=1, conv=0, w_rd_en=1, w_rd_addr=ROWS-1-j. Reverse order means row r of the tile ends in array row r.
- CONV cycle k (0..L-1):
  - prefetch=0, conv=1.
  - a_rd_en=1 and a_rd_addr=k for k<num_vec; otherwise a_rd_en=0 and a_rd_addr holds 0.
  - Per-row skew (row r delayed r cycles) is applied by the activation feeder, not this block.
- p_valid timing:
  - p_valid=1 for k in [ROWS+1, ROWS+num_vec], with p_idx=k-ROWS-1; otherwise p_valid=0 and p_idx=0.
  - Column c result for vector v appears c cycles after column 0's; output deskew is external.
- Weights are stationary during CONV: prefetch is never high together with conv.
- Outside PREFETCH and CONV, prefetch=conv=0, so MACs hold w and clear a/p.
- start while not IDLE (including the DONE cycle) is ignored; it is not queued.
- Counter widths must cover MAX_VEC+ROWS+COLS without wrap.
- busy=0 and done=1 in the DONE cycle.
- Back-to-back jobs: start asserted in the cycle after done is accepted, giving a minimum 1-cycle IDLE gap.

Test Plan:
- ROWS=COLS=4, num_vec=3, start pulsed at T0:
  - Prefetch T1..T4 with w_rd_addr 3,2,1,0.
  - conv T5..T15.
  - a_rd_en T5..T7 with addr 0,1,2.
  - p_valid T10..T12 with p_idx 0,1,2.
  - done T16; busy T1..T15.
- Same config with 4x4 MAC array and identity weights, activations 1,2,3 (skewed) -> column-0 p_o at T10..T12 equals the expected dot products, bit-exact.
- num_vec=0 -> prefetch T1..T4, done at T5, conv/a_rd_en/p_valid never high.
- start held high continuously with num_vec=2 -> second job enters PREFETCH one cycle after IDLE re-entry. start is ignored during busy and DONE. Exactly two done pulses in the window.
- rst=0 asserted in CONV cycle k=5 -> all outputs 0 asynchronously (before the next edge). After release, IDLE with no done pulse until a new start.
- num_vec=MAX_VEC (256) -> conv lasts 264 cycles with no counter wrap. Last p_valid has p_idx=255 at k=260.
